card_ram_arbiter: RTL
=====================

CARD_RAM_ARBITER -- requirements
Module: card_ram_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 6, card RAM address width.
- DATA_W, 6, card RAM word width; one encoded card per word.
- DECK_SIZE, 52, number of valid deck slots; addresses DECK_SIZE..2^ADDR_W-1 are out of range.

REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset are fixed as below:
- CLOCK_50 in 1: sole clock, rising edge.
- hardRes in 1: reset, asynchronous, active-high.
- shuf_req in 1: shuffler request.
- shuf_lock in 1: shuffler burst lock.
- shuf_we in 1: shuffler write enable.
- shuf_adr in ADDR_W: shuffler address.
- shuf_din in DATA_W: shuffler write data.
- shuf_ack out 1: shuffler transaction done, one-cycle pulse.
- get_req in 1: card-getter read request.
- get_adr in ADDR_W: card-getter address.
- get_ack out 1: card-getter done, one-cycle pulse.
- peek_req in 1: display/debug read request.
- peek_adr in ADDR_W: display/debug address.
- peek_ack out 1: display/debug done, one-cycle pulse.
- rdata out DATA_W: read data, valid while any ack is high.
- ram_adr out ADDR_W: to card RAM address.
- ram_din out DATA_W: to card RAM data.
- ram_we out 1: to card RAM write enable.
- ram_dout in DATA_W: from card RAM; valid the cycle after the address is latched.
- busy out 1: high in any state other than IDLE.
- owner out 2: current grant; 0 none, 1 shuf, 2 get, 3 peek.
- oob_err out 1: one-cycle pulse when a write is suppressed.

Function
REQ-003 FSM states and transitions: IDLE -> ACCESS -> RDWAIT -> ACK -> IDLE. Each state lasts exactly one cycle except IDLE.
REQ-004 Arbitration happens only in IDLE, at the edge where at least one req is high. On that edge the FSM latches the winner's address, write data and we into ram_adr/ram_din/ram_we, sets owner, and moves to ACCESS.
REQ-005 Default priority: shuf > get > peek.
REQ-006 The get and peek requesters are read-only; ram_we is 0 whenever they own the bus.
REQ-007 ram_we is high only during ACCESS and is cleared on the edge leaving ACCESS.
REQ-008 In RDWAIT the FSM samples ram_dout into rdata. In ACK the winner's ack is high for exactly one cycle, and rdata holds the word at ram_adr (the pre-write value for a write).
REQ-009 Latency: a req sampled at edge E gives ack high in the cycle after edge E+2. The next arbitration is no earlier than edge E+4. Throughput is one transaction per 4 cycles.
REQ-010 Requesters hold req, adr, we and din stable until they see ack, and drop req the cycle after ack. ACK never samples requests, so a held req is never double-granted.
REQ-011 Lock: if shuf_lock is high in ACK of a shuffler transaction, the FSM returns to IDLE with owner still 1, and only shuf_req is eligible. The lock releases when shuf_lock is low in IDLE; arbitration then resumes the same cycle.
REQ-012 A shuffler write with shuf_adr >= DECK_SIZE is still sequenced and acked, but ram_we stays 0 and oob_err pulses in the ACK cycle. Reads of any address are allowed.
REQ-013 Simultaneous requests: losers keep req asserted and are served in later IDLE arbitrations. No request is dropped.
REQ-014 owner returns to 0 in IDLE when not locked.

Reset
REQ-015 While hardRes is high, regardless of the current state: state = IDLE, owner = 0, ram_we = 0, ram_adr = 0, ram_din = 0, rdata = 0, all acks = 0, oob_err = 0, busy = 0, lock cleared.
REQ-016 Reset mid-transaction aborts it with no ack. A write aborted after ACCESS may or may not have reached the RAM.

Configuration
REQ-017 Macro CARD_ARB_RR_EN.
- Defined: get and peek share the lower priority tier round-robin. The last served of the two loses a tie, and the round-robin pointer resets to favour get.
- Undefined: fixed get > peek.
- Both builds: shuf keeps top priority.

Verification
REQ-018 Single read: reset, RAM[5]=0x2A, get_req with get_adr=5 -> get_ack exactly 3 edges later, rdata=0x2A, ram_we never high.
REQ-019 Contention: shuf_req (write adr 3, data 0x11) and get_req (adr 3) in the same IDLE edge -> shuf_ack first, then get_ack 4 cycles later with rdata=0x11.
REQ-020 Lock: shuf_lock high over 3 shuffler transactions while get_req is held -> get_ack only after lock drops; owner=1 throughout the burst.
REQ-021 Out-of-range: shuffler write to adr 52 -> shuf_ack and oob_err pulse, ram_we stays 0, RAM unchanged.
REQ-022 Reset: assert hardRes during RDWAIT -> all outputs at reset values asynchronously, no ack. After release, a pending get_req is served normally.
REQ-023 Fairness (CARD_ARB_RR_EN defined): get_req and peek_req both held continuously -> acks alternate get, peek, get, peek. With the macro undefined -> get only until get_req drops.

Source files
------------

// File: rtl/card_ram_arbiter.sv
`timescale 1ns/1ps
// Card RAM arbiter: shuffler, card-getter and display peek share one sync RAM.
// Define CARD_ARB_RR_EN for round-robin between get and peek (else get > peek).
module card_ram_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 6,
  parameter int DECK_SIZE = 52
) (
  input  logic              CLOCK_50,
  input  logic              hardRes,
  input  logic              shuf_req,
  input  logic              shuf_lock,
  input  logic              shuf_we,
  input  logic [ADDR_W-1:0] shuf_adr,
  input  logic [DATA_W-1:0] shuf_din,
  output logic              shuf_ack,
  input  logic              get_req,
  input  logic [ADDR_W-1:0] get_adr,
  output logic              get_ack,
  input  logic              peek_req,
  input  logic [ADDR_W-1:0] peek_adr,
  output logic              peek_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [1:0]        owner,
  output logic              oob_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    ACK
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_SHUF = 2'd1;
  localparam logic [1:0] OWN_GET  = 2'd2;
  localparam logic [1:0] OWN_PEEK = 2'd3;

  state_t     state;
  logic       locked;
  logic       oob_pend;
  logic [1:0] grant;
  logic [1:0] tie_pick;
  logic       oob_hit;

  assign oob_hit = 32'(shuf_adr) >= 32'(DECK_SIZE);
  assign busy    = (state != IDLE);

`ifdef CARD_ARB_RR_EN
  // rr_pref set means peek wins the next get/peek tie
  logic rr_pref;

  assign tie_pick = rr_pref ? OWN_PEEK : OWN_GET;

  always_ff @(posedge CLOCK_50 or posedge hardRes) begin
    if (hardRes) begin
      rr_pref <= 1'b0;
    end else if (state == IDLE) begin
      if (grant == OWN_GET)
        rr_pref <= 1'b1;
      else if (grant == OWN_PEEK)
        rr_pref <= 1'b0;
    end
  end
`else
  assign tie_pick = OWN_GET;
`endif

  // While a burst lock holds, only the shuffler may be granted
  always_comb begin
    grant = OWN_NONE;
    if (shuf_req)
      grant = OWN_SHUF;
    else if (locked && shuf_lock)
      grant = OWN_NONE;
    else if (get_req && peek_req)
      grant = tie_pick;
    else if (get_req)
      grant = OWN_GET;
    else if (peek_req)
      grant = OWN_PEEK;
  end

  always_ff @(posedge CLOCK_50 or posedge hardRes) begin
    if (hardRes) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      locked   <= 1'b0;
      oob_pend <= 1'b0;
      ram_adr  <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      rdata    <= '0;
      shuf_ack <= 1'b0;
      get_ack  <= 1'b0;
      peek_ack <= 1'b0;
      oob_err  <= 1'b0;
    end else begin
      shuf_ack <= 1'b0;
      get_ack  <= 1'b0;
      peek_ack <= 1'b0;
      oob_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          locked <= locked && shuf_lock;
          if (grant != OWN_NONE) begin
            state <= ACCESS;
            owner <= grant;
            if (grant == OWN_SHUF) begin
              ram_adr  <= shuf_adr;
              ram_din  <= shuf_din;
              ram_we   <= shuf_we && !oob_hit;
              oob_pend <= shuf_we && oob_hit;
            end else begin
              ram_adr  <= (grant == OWN_GET) ? get_adr : peek_adr;
              ram_din  <= '0;
              ram_we   <= 1'b0;
              oob_pend <= 1'b0;
            end
          end else begin
            owner <= (locked && shuf_lock) ? OWN_SHUF : OWN_NONE;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= RDWAIT;
        end
        RDWAIT: begin
          rdata   <= ram_dout;
          oob_err <= oob_pend;
          state   <= ACK;
          unique case (owner)
            OWN_SHUF: shuf_ack <= 1'b1;
            OWN_GET:  get_ack  <= 1'b1;
            OWN_PEEK: peek_ack <= 1'b1;
            default:  ;
          endcase
        end
        ACK: begin
          state    <= IDLE;
          oob_pend <= 1'b0;
          if (owner == OWN_SHUF && shuf_lock) begin
            locked <= 1'b1;
          end else begin
            locked <= 1'b0;
            owner  <= OWN_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
